// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and constants for the AES round controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    localparam logic [1:0] c_op_add_key     = 2'b00;
    localparam logic [1:0] c_op_full_round  = 2'b01;
    localparam logic [1:0] c_op_final_round = 2'b10;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

endpackage

`default_nettype wire

// File: rtl/aes_rcon_gen.sv
// ============================================================================
// Module      : aes_rcon_gen
// Description : Next AES round constant: 0x00 -> RCON_INIT, otherwise xtime.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic [7:0] i_rcon,
    output logic [7:0] o_rcon
);

    always_comb begin
        o_rcon = RCON_INIT;
        if (i_rcon != 8'h00) begin
            o_rcon = {i_rcon[6:0], 1'b0} ^ (i_rcon[7] ? RCON_POLY : 8'h00);
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module      : aes_round_ctrl
// Description : Round sequencer for an iterative AES datapath with ack timeout.
//               Optional abort input enabled by macro AES_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR      = 10,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       dp_load,
    output logic       dp_go,
    output logic [1:0] dp_op,
    output logic [3:0] dp_round,
    output logic [7:0] dp_rcon,
    input  logic       dp_ack,
`ifdef AES_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       err
);

    localparam int                c_tw         = $clog2(TIMEOUT + 1);
    localparam logic [3:0]        c_last_round = 4'(NR);
    localparam logic [c_tw-1:0]   c_timer_last = c_tw'(TIMEOUT - 1);

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_round, w_round_nxt;
    logic [7:0]      r_rcon,  w_rcon_nxt;
    logic [c_tw-1:0] r_timer, w_timer_nxt;
    logic            r_err,   w_err_nxt;
    logic [7:0]      w_rcon_adv;
    logic            w_abort;
    logic [1:0]      w_op;

`ifdef AES_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    aes_rcon_gen u_rcon_gen (
        .i_rcon (r_rcon),
        .o_rcon (w_rcon_adv)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_round <= 4'd0;
            r_rcon  <= 8'h00;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_rcon  <= w_rcon_nxt;
            r_timer <= w_timer_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_rcon_nxt  = r_rcon;
        w_timer_nxt = r_timer;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_LOAD;
                    w_round_nxt = 4'd0;
                    w_rcon_nxt  = 8'h00;
                end
            end
            ST_LOAD:  w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                w_timer_nxt = '0;
            end
            ST_WAIT: begin
                // An ack on the last permitted cycle wins over the timeout.
                if (dp_ack) begin
                    if (r_round == c_last_round) begin
                        w_state_nxt = ST_OUTPUT;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_round_nxt = r_round + 4'd1;
                        w_rcon_nxt  = w_rcon_adv;
                    end
                end else if (r_timer == c_timer_last) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + c_tw'(1);
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b0;
        end
    end

    always_comb begin
        w_op = c_op_full_round;
        if (r_round == 4'd0) begin
            w_op = c_op_add_key;
        end else if (r_round == c_last_round) begin
            w_op = c_op_final_round;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign dp_load   = (r_state == ST_LOAD);
    assign dp_go     = (r_state == ST_ISSUE);
    assign out_valid = (r_state == ST_OUTPUT);
    assign dp_op     = (r_state == ST_ISSUE) ? w_op : c_op_add_key;
    assign dp_round  = r_round;
    assign dp_rcon   = r_rcon;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Directed self-checking bench for aes_round_ctrl (NR=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_ctrl;

    localparam int NR      = 10;
    localparam int TIMEOUT = 255;
    localparam int CYC_MAX = 400;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic       dp_ack    = 1'b0;
`ifdef AES_ABORT_EN
    logic       abort     = 1'b0;
`endif
    logic       in_ready, out_valid, dp_load, dp_go, busy, err;
    logic [1:0] dp_op;
    logic [3:0] dp_round;
    logic [7:0] dp_rcon;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dp_load   (dp_load),
        .dp_go     (dp_go),
        .dp_op     (dp_op),
        .dp_round  (dp_round),
        .dp_rcon   (dp_rcon),
        .dp_ack    (dp_ack),
`ifdef AES_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .err       (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_rcon [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [1:0] exp_op   [0:10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                    2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    int         go_cnt;
    logic [3:0] go_round [0:15];
    logic [1:0] go_op    [0:15];
    logic [7:0] go_rcon  [0:15];
    int         ov_cycle;
    int         err_cnt;
    int         err_waits;
    logic       end_ready;
    logic       timed_out;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_in_ready"},  32'(in_ready),  32'd1);
        check_eq({pfx, "_busy"},      32'(busy),      32'd0);
        check_eq({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({pfx, "_dp_load"},   32'(dp_load),   32'd0);
        check_eq({pfx, "_dp_go"},     32'(dp_go),     32'd0);
        check_eq({pfx, "_err"},       32'(err),       32'd0);
        check_eq({pfx, "_dp_op"},     32'(dp_op),     32'd0);
        check_eq({pfx, "_dp_round"},  32'(dp_round),  32'd0);
        check_eq({pfx, "_dp_rcon"},   32'(dp_rcon),   32'd0);
    endtask

    // Runs one block; ack is offered in ISSUE and WAIT unless the stall round applies.
    task automatic run_block(input int stall_rnd, input int ack_at, input int rst_rnd,
                             input int abort_rnd);
        int   waits;
        logic wait_st;
        logic stalled;
        go_cnt    = 0;
        ov_cycle  = -1;
        err_cnt   = 0;
        err_waits = -1;
        end_ready = 1'b0;
        timed_out = 1'b1;
        waits     = 0;
        check_eq("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= CYC_MAX; cyc++) begin
            dp_ack = 1'b0;
`ifdef AES_ABORT_EN
            abort = 1'b0;
`endif
            if (err) begin
                err_cnt++;
                err_waits = waits;
            end
            if (dp_go) begin
                if (go_cnt < 16) begin
                    go_round[go_cnt] = dp_round;
                    go_op[go_cnt]    = dp_op;
                    go_rcon[go_cnt]  = dp_rcon;
                end
                go_cnt++;
                waits = 0;
            end
            wait_st = busy && !dp_go && !dp_load && !out_valid;
            if (wait_st) waits++;
            if (out_valid) begin
                ov_cycle  = cyc;
                timed_out = 1'b0;
                break;
            end
            if (!busy) begin
                end_ready = in_ready;
                timed_out = 1'b0;
                break;
            end
            if (wait_st && int'(dp_round) == rst_rnd) begin
                rst = 1'b0;
                #1;
                timed_out = 1'b0;
                break;
            end
`ifdef AES_ABORT_EN
            if (wait_st && int'(dp_round) == abort_rnd) abort = 1'b1;
`endif
            stalled = (int'(dp_round) == stall_rnd) && (ack_at == 0 || waits < ack_at);
            dp_ack  = (dp_go || wait_st) && !stalled;
            @(posedge clk); #1;
        end
        dp_ack = 1'b0;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        check_eq("cycle_bound", 32'(timed_out), 32'd0);
    endtask

    task automatic check_trace(input string pfx);
        check_eq({pfx, "_go_count"}, 32'(go_cnt), 32'(NR + 1));
        for (int r = 0; r <= NR; r++) begin
            check_eq($sformatf("%s_r%0d_round", pfx, r), 32'(go_round[r]), 32'(r));
            check_eq($sformatf("%s_r%0d_op", pfx, r),    32'(go_op[r]),    32'(exp_op[r]));
            check_eq($sformatf("%s_r%0d_rcon", pfx, r),  32'(go_rcon[r]),  32'(exp_rcon[r]));
        end
    endtask

    task automatic drain(input int hold);
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_out_valid", 32'(out_valid), 32'd1);
            check_eq("hold_in_ready",  32'(in_ready),  32'd0);
            in_valid  = i[0];
            out_ready = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("drain_in_ready",  32'(in_ready),  32'd1);
        check_eq("drain_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_eq("drain_no_reaccept", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        run_block(-1, 0, -1, -1);
        check_trace("nominal");
        check_eq("nominal_latency", 32'(ov_cycle), 32'd24);
        check_eq("nominal_err",     32'(err_cnt),  32'd0);
        drain(5);

        run_block(3, 0, -1, -1);
        check_eq("timeout_err_count", 32'(err_cnt),   32'd1);
        check_eq("timeout_waits",     32'(err_waits), 32'(TIMEOUT));
        check_eq("timeout_in_ready",  32'(end_ready), 32'd1);
        check_eq("timeout_go_count",  32'(go_cnt),    32'd4);
        check_eq("timeout_no_output", 32'(ov_cycle),  32'hffffffff);
        @(posedge clk); #1;
        check_eq("timeout_err_width", 32'(err), 32'd0);

        run_block(3, TIMEOUT, -1, -1);
        check_eq("lastack_err", 32'(err_cnt), 32'd0);
        check_trace("lastack");
        check_eq("lastack_latency", 32'(ov_cycle), 32'd278);
        drain(0);

        run_block(-1, 0, 5, -1);
        check_reset("midrst");
        check_eq("midrst_go_count", 32'(go_cnt), 32'd6);
        @(posedge clk); #1;
        check_reset("midrst_hold");
        rst = 1'b1;
        @(posedge clk); #1;
        run_block(-1, 0, -1, -1);
        check_trace("postrst");
        check_eq("postrst_latency", 32'(ov_cycle), 32'd24);
        drain(0);

`ifdef AES_ABORT_EN
        run_block(-1, 0, -1, 7);
        check_eq("abort_in_ready",  32'(end_ready), 32'd1);
        check_eq("abort_no_output", 32'(ov_cycle),  32'hffffffff);
        check_eq("abort_err",       32'(err_cnt),   32'd0);
        check_eq("abort_go_count",  32'(go_cnt),    32'd8);
        @(posedge clk); #1;
        check_eq("abort_err_after", 32'(err),       32'd0);
        check_eq("abort_idle",      32'(busy),      32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
